cnn_column_feeder: RTL and testbench
====================================

# cnn_column_feeder

Raster-to-column front end for the convolution window stage. It accepts one pixel per handshake in row-major order and keeps the previous KERNEL_HEIGHT-1 image lines in line buffers. For every pixel accepted in row KERNEL_HEIGHT-1 or later, it emits one KERNEL_HEIGHT-tall column, packed in the layout the sliding-window convolver consumes on its column input. It sits between the pixel source (DMA or previous layer) and the sliding-window convolver, and adds ready/valid flow control with frame framing.

## Interface
- IMG_WIDTH, 32: pixels per line (≥ KERNEL_WIDTH)
- IMG_HEIGHT, 32: lines per frame (≥ KERNEL_HEIGHT)
- KERNEL_WIDTH, 3: window width; used only for out_win_valid
- KERNEL_HEIGHT, 3: column height (≥ 2)
- DATA_WIDTH, 16: pixel width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  DATA_WIDTH  pixel
- in_sof  in  1  marks the first pixel of a frame; sampled only on accept
- in_valid  in  1  pixel present
- in_ready  out  1  pixel accepted when in_valid && in_ready
- out_col  out  KERNEL_HEIGHT*DATA_WIDTH  column; slice i = [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH], i=0 oldest (top) line, i=KERNEL_HEIGHT-1 newest pixel
- out_valid  out  1  column present
- out_ready  in  1  column consumed when out_valid && out_ready
- out_win_valid  out  1  qualifier with out_valid: column index ≥ KERNEL_WIDTH-1, so a full window is formed downstream
- out_eol  out  1  qualifier: last column of a line
- out_last  out  1  qualifier: last column of the frame

## Operation
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on every accept. col wraps at IMG_WIDTH-1 and increments row. row wraps at IMG_HEIGHT-1.
- States:
  - FILL: row < KERNEL_HEIGHT-1. Accepts produce no output; in_ready=1.
  - STREAM: row ≥ KERNEL_HEIGHT-1. Every accept loads the output register.
  - The last accepted pixel of a frame returns the block to FILL with row=col=0.
- Line buffers lb[0..KERNEL_HEIGHT-2], each IMG_WIDTH entries, addressed by col, read-before-write.
- On accept at column c, the block reads all lb[k][c]. It outputs {in_data, lb[KERNEL_HEIGHT-2][c], ..., lb[0][c]}, with lb[0] in slice 0. It then writes lb[k][c] ← lb[k+1][c], and lb[KERNEL_HEIGHT-2][c] ← in_data.
- Flow control: in_ready = !out_valid || out_ready in STREAM, and 1 in FILL. out_col and the qualifiers stay stable while out_valid && !out_ready.
- Qualifiers are registered with out_col:
  - out_win_valid = (c ≥ KERNEL_WIDTH-1)
  - out_eol = (c == IMG_WIDTH-1)
  - out_last = out_eol && row == IMG_HEIGHT-1
- in_sof accepted at any position: that pixel is treated as (row 0, col 0), and the state is forced to FILL. A pending output already in the register is still delivered. Early in_sof truncates the current frame with no out_last.
- Reset:
  - out_valid=0, out_win_valid=0, out_eol=0, out_last=0, out_col=0; in_ready=1 one cycle after reset.
  - row=col=0, state FILL.
  - Line buffer contents are not cleared. Stale data is never emitted, because FILL rewrites every entry before STREAM.
- Reset mid-frame discards the in-flight column. The first pixel after reset is treated as (0,0) regardless of in_sof.

## Timing
- Latency: pixel accepted in cycle t → out_valid in cycle t+1.
- Throughput: 1 pixel/cycle when out_ready stays high.
- Same-cycle output consume and new input accept is legal in STREAM: the register reloads with no bubble.
- FILL takes (KERNEL_HEIGHT-1)*IMG_WIDTH accepts with no output.
- Output columns per frame: (IMG_HEIGHT-KERNEL_HEIGHT+1)*IMG_WIDTH.

## Structure
- Shared package cnn_pkg:
  - state enum {FILL, STREAM}
  - helper function for counter width, $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT)
- Sub-module cnn_line_ram: single-port, read-before-write, DATA_WIDTH × IMG_WIDTH, synchronous write. Instantiated KERNEL_HEIGHT-1 times.
- Output register, counters and FSM live in the top module.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, KERNEL_HEIGHT=3, KERNEL_WIDTH=3, DATA_WIDTH=16; pixel value = 4*row+col.

- **Continuous frame, out_ready=1:**
  - Pixels 0..15 → first out_valid the cycle after pixel 8, out_col slices {0,4,8}.
  - Exactly 8 columns.
  - out_win_valid only on columns from pixels 10, 11, 14, 15.
  - out_last with column {7,11,15}.
- **Backpressure:** hold out_ready=0 after pixel 9 for 5 cycles → in_ready=0, out_col holds {1,5,9}, no pixels lost. Release → remaining columns in order.
- **Back-to-back frames:** second frame values 100+n, with no idle cycle between frames → no output during its first 8 pixels. Its first column is {100,104,108}; no data from frame 1 leaks into it.
- **Early in_sof:** assert in_sof on pixel 10 of frame 1 (value 10) → column for pixel 9 is still delivered. Pixel 10 restarts FILL, and the next output appears 8 accepts later.
- **Reset mid-frame:** assert reset for 1 cycle after pixel 12, while out_valid=1 → next cycle out_valid=0 and all qualifiers are 0. A new frame 0..15 then reproduces scenario 1 exactly.
- **Random in_valid/out_ready gaps** (50% duty) → output sequence identical to scenario 1; in_ready never high while out_valid && !out_ready.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN column feeder.
package cnn_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Counter width for a range of n positions; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_line_ram.sv
// One image line of storage. Asynchronous read, synchronous write, so a
// read and write of the same address in one cycle returns the old value.
module cnn_line_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Contents are intentionally not reset; the fill phase rewrites every entry.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/cnn_column_feeder.sv
// Raster-to-column front end: buffers KERNEL_HEIGHT-1 lines and emits one
// KERNEL_HEIGHT-tall column per pixel once enough lines are available.
module cnn_column_feeder
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH     = 32,
  parameter int IMG_HEIGHT    = 32,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_sof,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] out_col,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_win_valid,
  output logic                                out_eol,
  output logic                                out_last
);

  localparam int CW  = cnt_w(IMG_WIDTH);
  localparam int RW  = cnt_w(IMG_HEIGHT);
  localparam int NLB = KERNEL_HEIGHT - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_STRM = RW'(KERNEL_HEIGHT - 1);

  state_e                          state_q, state_d;
  logic [CW-1:0]                   col_q, col_d, cur_col;
  logic [RW-1:0]                   row_q, row_d, cur_row;
  logic                            accept, emit;
  logic [NLB-1:0][DATA_WIDTH-1:0]  lb_rd, lb_wd;

  logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] col_q_r;
  logic                                vld_q, win_q, eol_q, last_q;

  // FILL never produces output, so it may accept even with a column pending.
  assign in_ready = (state_q == FILL) || !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel re-anchors the position to (0,0).
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;
  assign emit    = accept && !in_sof && (state_q == STREAM);

  // Line buffers shift one line up per accept at the current column.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == NLB - 1) begin : g_top
      assign lb_wd[k] = in_data;
    end else begin : g_mid
      assign lb_wd[k] = lb_rd[k+1];
    end
    cnn_line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .AW         (CW)
    ) u_lb (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (cur_col),
      .wdata_i (lb_wd[k]),
      .rdata_o (lb_rd[k])
    );
  end

  // Next raster position and the phase it implies.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      state_d = (row_d >= ROW_STRM) ? STREAM : FILL;
    end
  end

  // Position counters and phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
    end
  end

  // Output register: load on a streaming accept, clear valid once consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q_r <= '0;
      vld_q   <= 1'b0;
      win_q   <= 1'b0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (emit) begin
      col_q_r <= {in_data, lb_rd};
      vld_q   <= 1'b1;
      win_q   <= (cur_col >= COL_WIN);
      eol_q   <= (cur_col == COL_LAST);
      last_q  <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end else if (out_ready) begin
      vld_q   <= 1'b0;
    end
  end

  assign out_col       = col_q_r;
  assign out_valid     = vld_q;
  assign out_win_valid = win_q;
  assign out_eol       = eol_q;
  assign out_last      = last_q;

endmodule

// File: tb/tb_cnn_column_feeder.sv
// Self-checking bench for cnn_column_feeder with a raster-position model.
module tb_cnn_column_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KW = 3;
  localparam int KH = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_sof, in_valid, in_ready;
  logic [KH*DW-1:0] out_col;
  logic          out_valid, out_ready, out_win_valid, out_eol, out_last;

  int   or_mode;   // 0: ready high, 1: ready low, 2: random
  logic rnd_bit;
  bit   rnd_gap;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int n_win  = 0;
  int n_last = 0;

  typedef struct packed {
    logic [KH*DW-1:0] col;
    logic             win;
    logic             eol;
    logic             last;
  } exp_t;

  exp_t          q[$];
  int            m_row, m_col;
  logic [DW-1:0] img [H][W];

  always #5 clk = ~clk;

  always @(posedge clk) #1 rnd_bit = 1'($urandom_range(0, 1));
  assign out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'b0 : rnd_bit;

  cnn_column_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_WIDTH(KW),
    .KERNEL_HEIGHT(KH), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_win_valid(out_win_valid), .out_eol(out_eol), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: remember every pixel by its frame position; a column is the
  // same image column taken from the current and the two previous rows.
  always @(negedge clk) begin
    exp_t e;
    int   r, c;
    if (reset) begin
      q.delete();
      m_row = 0;
      m_col = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_col", 64'(out_col), 64'hdead);
        else begin
          e = q.pop_front();
          chk("col",  64'(out_col),       64'(e.col));
          chk("win",  64'(out_win_valid), 64'(e.win));
          chk("eol",  64'(out_eol),       64'(e.eol));
          chk("last", 64'(out_last),      64'(e.last));
        end
        n_out++;
        if (out_win_valid) n_win++;
        if (out_last)      n_last++;
      end
      if (out_valid && !out_ready && m_row >= KH - 1)
        chk("bp_ready", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) begin
        r = in_sof ? 0 : m_row;
        c = in_sof ? 0 : m_col;
        img[r][c] = in_data;
        if (r >= KH - 1) begin
          e.col  = {in_data, img[r-1][c], img[r-2][c]};
          e.win  = (c >= KW - 1);
          e.eol  = (c == W - 1);
          e.last = (c == W - 1) && (r == H - 1);
          q.push_back(e);
        end
        m_col = c + 1;
        m_row = r;
        if (m_col == W) begin
          m_col = 0;
          m_row = (r == H - 1) ? 0 : r + 1;
        end
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sof);
    bit acc;
    int t = 0;
    if (rnd_gap) repeat ($urandom_range(0, 1)) idle();
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 64'(t), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      idle();
      t++;
    end
    if (t >= 100) chk("drain_timeout", 64'(t), 64'd0);
  endtask

  initial begin
    int n0, w0, l0;
    or_mode  = 0;
    rnd_gap  = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_col",   64'(out_col),   64'd0);
    chk("rst_quals", 64'({out_win_valid, out_eol, out_last}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Continuous frame
    n0 = n_out; w0 = n_win; l0 = n_last;
    for (int i = 0; i < 16; i++) begin
      send(16'(i), i == 0);
      if (i == 7) chk("fill_no_vld", 64'(out_valid), 64'd0);
      if (i == 8) begin
        chk("lat_vld",   64'(out_valid), 64'd1);
        chk("first_col", 64'(out_col),   {16'd0, 16'd8, 16'd4, 16'd0});
      end
    end
    drain();
    chk("s1_cols", 64'(n_out - n0),  64'd8);
    chk("s1_win",  64'(n_win - w0),  64'd4);
    chk("s1_last", 64'(n_last - l0), 64'd1);

    // Backpressure after pixel 9
    n0 = n_out;
    for (int i = 0; i < 10; i++) send(16'(i), i == 0);
    or_mode  = 1;
    in_data  = 16'd10;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold",     64'(out_col),  {16'd0, 16'd9, 16'd5, 16'd1});
    end
    @(posedge clk); #1;
    or_mode = 0;
    for (int i = 10; i < 16; i++) send(16'(i), 1'b0);
    drain();
    chk("bp_cols", 64'(n_out - n0), 64'd8);

    // Back-to-back frames
    n0 = n_out;
    for (int i = 0; i < 16; i++) send(16'(i), i == 0);
    for (int i = 0; i < 16; i++) begin
      send(16'(100 + i), i == 0);
      if (i == 8) chk("b2b_first", 64'(out_col), {16'd0, 16'd108, 16'd104, 16'd100});
    end
    drain();
    chk("b2b_cols", 64'(n_out - n0), 64'd16);

    // Early in_sof on pixel 10
    n0 = n_out; l0 = n_last;
    for (int i = 0; i < 10; i++) send(16'(i), i == 0);
    send(16'd10, 1'b1);
    chk("sof_no_new", 64'(out_valid), 64'd0);
    for (int i = 11; i < 26; i++) begin
      send(16'(i), 1'b0);
      if (i == 17) chk("sof_fill", 64'(out_valid), 64'd0);
      if (i == 18) begin
        chk("sof_resume", 64'(out_valid), 64'd1);
        chk("sof_col",    64'(out_col),   {16'd0, 16'd18, 16'd14, 16'd10});
      end
    end
    drain();
    chk("sof_cols", 64'(n_out - n0),  64'd10);
    chk("sof_last", 64'(n_last - l0), 64'd1);

    // Reset mid-frame with a column pending
    for (int i = 0; i < 13; i++) send(16'(i), i == 0);
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_vld",   64'(out_valid), 64'd0);
    chk("mid_rst_quals", 64'({out_win_valid, out_eol, out_last}), 64'd0);
    n0 = n_out; w0 = n_win; l0 = n_last;
    for (int i = 0; i < 16; i++) begin
      send(16'(i), 1'b0);
      if (i == 8) chk("rst_first_col", 64'(out_col), {16'd0, 16'd8, 16'd4, 16'd0});
    end
    drain();
    chk("rst_cols", 64'(n_out - n0),  64'd8);
    chk("rst_win",  64'(n_win - w0),  64'd4);
    chk("rst_last", 64'(n_last - l0), 64'd1);

    // Random gaps on both sides
    n0 = n_out; l0 = n_last;
    or_mode = 2;
    rnd_gap = 1;
    for (int i = 0; i < 16; i++) send(16'(i), i == 0);
    for (int i = 0; i < 16; i++) send(16'($urandom), i == 0);
    drain();
    or_mode = 0;
    rnd_gap = 0;
    idle();
    chk("rnd_cols", 64'(n_out - n0),  64'd16);
    chk("rnd_last", 64'(n_last - l0), 64'd2);
    chk("q_empty",  64'(q.size()),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
